alu_result_stage: RTL and testbench

//  Pipeline register directly downstream of the ALU result mux. Captures the 32-bit ALU

---
 rtl/alu_result_stage.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_result_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//   Pipeline register sitting directly after the ALU result mux. Each entry
//   holds the ALU result, destination tag, the instruction's set-flags bit and
//   the N/Z flags derived from the result at capture time.
//
//   A two-entry skid buffer (head + skid) decouples upstream ready from
//   downstream ready: in_ready is a function of the stored state (and reset)
//   only, so writeback back-pressure never forms a combinational path back
//   into the ALU / decode stages.
//
//   Optional feature macro: ALU_RESULT_STAGE_STALL_CNT_EN
//     defined   : stall_cnt counts cycles with out_valid & ~out_ready,
//                 saturating at 16'hFFFF, cleared only by rst.
//     undefined : no counter is built, stall_cnt is tied to 16'h0000.
// -----------------------------------------------------------------------------
module alu_result_stage #(
    parameter int bits    = 32,
    parameter int tagBits = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [bits-1:0]    in_result,
    input  logic [tagBits-1:0] in_tag,
    input  logic               in_setflags,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [bits-1:0]    out_result,
    output logic [tagBits-1:0] out_tag,
    output logic               out_n,
    output logic               out_z,
    output logic               out_flag_we,
    output logic [15:0]        stall_cnt
);

    // Occupancy of the two-entry buffer: nothing, head only, head + skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Negative flag: the sign bit of the result.
    function automatic logic calc_n(input logic [bits-1:0] value);
        return value[bits-1];
    endfunction

    // Zero flag: every result lane is zero.
    function automatic logic calc_z(input logic [bits-1:0] value);
        return (value == {bits{1'b0}});
    endfunction

    state_t             state_r;
    state_t             state_next_s;

    logic               in_ready_s;
    logic               out_valid_s;
    logic               accept_s;
    logic               emit_s;

    logic               load_head_in_s;
    logic               load_head_skid_s;
    logic               load_skid_s;

    logic [bits-1:0]    head_result_r;
    logic [tagBits-1:0] head_tag_r;
    logic               head_n_r;
    logic               head_z_r;
    logic               head_fwe_r;

    logic [bits-1:0]    skid_result_r;
    logic [tagBits-1:0] skid_tag_r;
    logic               skid_n_r;
    logic               skid_z_r;
    logic               skid_fwe_r;

    // Handshake terms. in_ready looks only at stored state and reset, so it
    // cannot depend combinationally on out_ready.
    assign in_ready_s  = (state_r != ST_FULL) & ~rst;
    assign out_valid_s = (state_r != ST_EMPTY);
    assign accept_s    = in_valid & in_ready_s;
    assign emit_s      = out_valid_s & out_ready;

    // State register: buffer occupancy, discarded by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: occupancy follows accepts and emits.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_next_s = ST_ONE;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && !emit_s) begin
                    state_next_s = ST_FULL;
                end else if (emit_s && !accept_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (emit_s) begin
                    state_next_s = ST_ONE;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // Output/control decode: which entry registers load this cycle.
    always_comb begin
        load_head_in_s   = 1'b0;
        load_head_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    load_head_in_s = 1'b1;
                end else begin
                    load_head_in_s = 1'b0;
                end
            end
            ST_ONE: begin
                if (accept_s && emit_s) begin
                    // Head leaves and the new word replaces it in the same cycle.
                    load_head_in_s = 1'b1;
                end else if (accept_s) begin
                    // Head is stuck, park the new word in the skid slot.
                    load_skid_s = 1'b1;
                end else begin
                    load_head_in_s = 1'b0;
                end
            end
            ST_FULL: begin
                if (emit_s) begin
                    load_head_skid_s = 1'b1;
                end else begin
                    load_head_skid_s = 1'b0;
                end
            end
            default: begin
                load_head_in_s   = 1'b0;
                load_head_skid_s = 1'b0;
                load_skid_s      = 1'b0;
            end
        endcase
    end

    // Head entry: drives the outputs directly; held while not emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_result_r <= {bits{1'b0}};
            head_tag_r    <= {tagBits{1'b0}};
            head_n_r      <= 1'b0;
            head_z_r      <= 1'b0;
            head_fwe_r    <= 1'b0;
        end else if (load_head_in_s) begin
            head_result_r <= in_result;
            head_tag_r    <= in_tag;
            head_n_r      <= calc_n(in_result);
            head_z_r      <= calc_z(in_result);
            head_fwe_r    <= in_setflags;
        end else if (load_head_skid_s) begin
            head_result_r <= skid_result_r;
            head_tag_r    <= skid_tag_r;
            head_n_r      <= skid_n_r;
            head_z_r      <= skid_z_r;
            head_fwe_r    <= skid_fwe_r;
        end else begin
            head_result_r <= head_result_r;
            head_tag_r    <= head_tag_r;
            head_n_r      <= head_n_r;
            head_z_r      <= head_z_r;
            head_fwe_r    <= head_fwe_r;
        end
    end

    // Skid entry: catches the word accepted while the head is blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_result_r <= {bits{1'b0}};
            skid_tag_r    <= {tagBits{1'b0}};
            skid_n_r      <= 1'b0;
            skid_z_r      <= 1'b0;
            skid_fwe_r    <= 1'b0;
        end else if (load_skid_s) begin
            skid_result_r <= in_result;
            skid_tag_r    <= in_tag;
            skid_n_r      <= calc_n(in_result);
            skid_z_r      <= calc_z(in_result);
            skid_fwe_r    <= in_setflags;
        end else begin
            skid_result_r <= skid_result_r;
            skid_tag_r    <= skid_tag_r;
            skid_n_r      <= skid_n_r;
            skid_z_r      <= skid_z_r;
            skid_fwe_r    <= skid_fwe_r;
        end
    end

`ifdef ALU_RESULT_STAGE_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Back-pressure counter: one count per blocked cycle, sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (out_valid_s && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 16'h0000;
`endif

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_s;
    assign out_result  = head_result_r;
    assign out_tag     = head_tag_r;
    assign out_n       = head_n_r;
    assign out_z       = head_z_r;
    assign out_flag_we = head_fwe_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_result_stage
//   Table-driven vectors plus hand-written sequences for the buffer corner
//   cases. Every accepted input pushes its expected output record onto a
//   scoreboard queue; every completed emit pops and compares it.
// -----------------------------------------------------------------------------
module tb_alu_result_stage;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  tag;
        logic        n;
        logic        z;
        logic        fwe;
    } exp_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        sf;
        logic        n;
        logic        z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = 32'h0;
    logic [3:0]  in_tag = 4'h0;
    logic        in_setflags = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic        out_n;
    logic        out_z;
    logic        out_flag_we;
    logic [15:0] stall_cnt;

    int   tot = 0;
    int   bad = 0;
    exp_t sb_q[$];
    exp_t cur_exp;
    logic last_acc = 1'b0;
    logic hold_v = 1'b0;
    logic [31:0] hold_res;
    logic [3:0]  hold_tag;
    vec_t tbl[8];

    alu_result_stage #(.bits(32), .tagBits(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_tag(in_tag), .in_setflags(in_setflags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .out_n(out_n), .out_z(out_z), .out_flag_we(out_flag_we),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] t, input logic sf);
        in_valid    = v;
        in_result   = d;
        in_tag      = t;
        in_setflags = sf;
        cur_exp.result = d;
        cur_exp.tag    = t;
        cur_exp.n      = d[31];
        cur_exp.z      = (d == 32'h0);
        cur_exp.fwe    = sf;
    endtask

    // Mid-cycle asynchronous reset pulse spanning one falling edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_flags", {out_tag, out_n, out_z, out_flag_we}, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        sb_q.delete();
        in_valid = 1'b0;
        step();
        chk("rst_in_ready_held", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
    endtask

    // Scoreboard monitor, sampling mid-cycle the handshakes of the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_v   = 1'b0;
            last_acc = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_result", out_result, hold_res);
                chk("hold_tag", out_tag, hold_tag);
                chk("hold_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_emit", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_result", out_result, e.result);
                    chk("sb_tag", out_tag, e.tag);
                    chk("sb_n", out_n, e.n);
                    chk("sb_z", out_z, e.z);
                    chk("sb_flag_we", out_flag_we, e.fwe);
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(cur_exp);
                last_acc = 1'b1;
            end else begin
                last_acc = 1'b0;
            end
            hold_v   = out_valid && !out_ready;
            hold_res = out_result;
            hold_tag = out_tag;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int          n_wait;
        tbl[0] = '{32'h0000_0005, 4'h1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0000, 4'h2, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{32'h8000_0000, 4'h3, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{32'h7FFF_FFFF, 4'h4, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{32'h0000_0001, 4'h0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{32'h0000_0000, 4'hA, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{32'h8000_0001, 4'h5, 1'b0, 1'b1, 1'b0};

        // Reset state while rst is held from time zero.
        #1;
        chk("init_out_valid", out_valid, 0);
        chk("init_in_ready", in_ready, 0);
        chk("init_stall_cnt", stall_cnt, 0);
        step();
        rst = 1'b0;
        #1;
        chk("init_release_in_ready", in_ready, 1);

        // Put something in flight, then reset asynchronously mid-cycle.
        out_ready = 1'b0;
        drive(1'b1, 32'h1234_5678, 4'h6, 1'b1);
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        do_reset();

        // Back-to-back stream from the vector table, one-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].res, tbl[i].tag, tbl[i].sf);
            cur_exp.n = tbl[i].n;
            cur_exp.z = tbl[i].z;
            chk("stream_in_ready", in_ready, 1);
            step();
            chk("stream_lat_valid", out_valid, 1);
            chk("stream_lat_result", out_result, tbl[i].res);
            chk("stream_lat_nz", {out_n, out_z}, {tbl[i].n, tbl[i].z});
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_valid", out_valid, 0);
        chk("stream_sb_empty", sb_q.size(), 0);

        // Fill both entries under back-pressure, C must wait.
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 4'h1, 1'b0);
        step();
        drive(1'b1, 32'h22, 4'h2, 1'b1);
        step();
        chk("full_in_ready", in_ready, 0);
        chk("full_head", out_result, 32'h11);
        drive(1'b1, 32'h33, 4'h3, 1'b0);
        step();
        step();
        chk("full_still_head", out_result, 32'h11);
        chk("full_still_blocked", in_ready, 0);
        out_ready = 1'b1;
        step();
        chk("drain_head_b", out_result, 32'h22);
        chk("drain_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("drain_head_c", out_result, 32'h33);
        chk("drain_valid_c", out_valid, 1);
        step();
        chk("drain_empty", out_valid, 0);
        chk("drain_sb_empty", sb_q.size(), 0);

        // ONE state with simultaneous accept and emit.
        out_ready = 1'b0;
        drive(1'b1, 32'h7, 4'h7, 1'b1);
        step();
        drive(1'b1, 32'h9, 4'h9, 1'b0);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("swap_head", out_result, 32'h9);
        chk("swap_tag", out_tag, 4'h9);
        chk("swap_in_ready", in_ready, 1);
        step();
        chk("swap_drained", out_valid, 0);

        // Reset while FULL discards both entries.
        out_ready = 1'b0;
        drive(1'b1, 32'hA1, 4'h1, 1'b1);
        step();
        drive(1'b1, 32'hA2, 4'h2, 1'b1);
        step();
        in_valid = 1'b0;
        chk("full2_in_ready", in_ready, 0);
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 32'h3, 4'h3, 1'b0);
        step();
        in_valid = 1'b0;
        chk("post_rst_result", out_result, 32'h3);
        step();
        chk("post_rst_sb_empty", sb_q.size(), 0);
        chk("post_rst_drained", out_valid, 0);

        // Stall counter over ten blocked cycles.
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h55, 4'h5, 1'b0);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
`ifdef ALU_RESULT_STAGE_STALL_CNT_EN
        chk("stall_cnt_10", stall_cnt, 10);
`else
        chk("stall_cnt_off", stall_cnt, 0);
`endif
        out_ready = 1'b1;
        step();
`ifdef ALU_RESULT_STAGE_STALL_CNT_EN
        chk("stall_cnt_after_emit", stall_cnt, 10);
`else
        chk("stall_cnt_off_after", stall_cnt, 0);
`endif
        chk("stall_drained", out_valid, 0);

        // Random traffic with random back-pressure; upstream holds until accepted.
        in_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || last_acc) begin
                case ($urandom_range(0, 3))
                    0:       d = 32'h0;
                    1:       d = 32'h8000_0000 | $urandom;
                    default: d = $urandom;
                endcase
                drive(($urandom_range(0, 3) != 0), d, 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)));
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_wait = 0;
        while (sb_q.size() != 0 && n_wait < 10) begin
            step();
            n_wait++;
        end
        step();
        chk("rand_sb_empty", sb_q.size(), 0);
        chk("rand_drained", out_valid, 0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
